seq_fp_div: RTL

SEQ_FP_DIV -- requirements
Module: seq_fp_div

---
 rtl/seq_fp_div_pkg.sv | 19 +
 rtl/seq_fp_div_mant.sv | 57 +++++
 rtl/seq_fp_div.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_fp_div_pkg.sv
// Shared definitions for the sequential single-precision divider:
// default bias and quotient length, IEEE-754 field widths, FSM state codes.
package seq_fp_div_pkg;

  localparam int unsigned FP_BIAS    = 127;
  localparam int unsigned FP_QBITS   = 25;
  localparam int unsigned EXP_W      = 8;
  localparam int unsigned MANT_W     = 23;
  localparam int unsigned SIG_W      = MANT_W + 1;
  localparam int unsigned EXP_CALC_W = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DIV  = 2'd1;
  localparam state_t ST_NORM = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/seq_fp_div_mant.sv
// Iterative restoring mantissa divider: q = floor((ma << (QBITS-1)) / mb),
// one quotient bit per cycle, MSB first.
// Ports: clk, rst (async, active-low), start (load ma/mb and begin),
//        ma/mb (24-bit significands with hidden bit), done_c (last bit this
//        cycle), q (quotient shift register).
module fp_div_mant
  import seq_fp_div_pkg::*;
#(
  parameter int unsigned QBITS = FP_QBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIG_W-1:0] ma,
  input  logic [SIG_W-1:0] mb,
  output logic             done_c,
  output logic [QBITS-1:0] q
);

  localparam int unsigned CNT_W = $clog2(QBITS);

  logic [SIG_W:0]   rem;
  logic [SIG_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             ge;
  logic [SIG_W-1:0] diff;

  // Trial subtraction; remainder always stays below 2*mb so it fits SIG_W+1 bits.
  always_comb begin
    ge     = rem >= {1'b0, div};
    diff   = SIG_W'(rem - {1'b0, div});
    done_c = busy && (cnt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem  <= '0;
      div  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      q    <= '0;
    end else if (start) begin
      rem  <= {1'b0, ma};
      div  <= mb;
      cnt  <= CNT_W'(QBITS - 1);
      busy <= 1'b1;
      q    <= '0;
    end else if (busy) begin
      rem <= ge ? {diff, 1'b0} : {rem[SIG_W-1:0], 1'b0};
      q   <= {q[QBITS-2:0], ge};
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_fp_div.sv
// Sequential IEEE-754 single-precision divider F = A / B (truncating, no NaN
// handling, denormals flushed). Latency QBITS+1 cycles from acceptance.
// Ports: clk, rst (async, active-low), in_valid/in_ready + A/B operands,
//        out_valid/out_ready + F quotient and dz divide-by-zero flag.
module seq_fp_div
  import seq_fp_div_pkg::*;
#(
  parameter int unsigned BIAS  = FP_BIAS,
  parameter int unsigned QBITS = FP_QBITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] F,
  output logic        dz
);

  state_t state, state_n;

  logic             sign_q;
  logic             bz_q;
  logic             az_q;
  logic [EXP_W-1:0] ea_q;
  logic [EXP_W-1:0] eb_q;

  logic             start_c;
  logic             mant_done_c;
  logic [QBITS-1:0] q;

  logic                  norm_lo_c;
  logic [EXP_CALC_W-1:0] e_c;
  logic [MANT_W-1:0]     frac_c;
  logic [31:0]           f_c;
  logic                  dz_c;

  assign start_c = (state == ST_IDLE) && in_valid;

  fp_div_mant #(.QBITS(QBITS)) u_mant (
    .clk    (clk),
    .rst    (rst),
    .start  (start_c),
    .ma     ({1'b1, A[MANT_W-1:0]}),
    .mb     ({1'b1, B[MANT_W-1:0]}),
    .done_c (mant_done_c),
    .q      (q)
  );

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (in_valid)    state_n = ST_DIV;
      ST_DIV:  if (mant_done_c) state_n = ST_NORM;
      ST_NORM:                  state_n = ST_DONE;
      ST_DONE: if (out_ready)   state_n = ST_IDLE;
      default:                  state_n = ST_IDLE;
    endcase
  end

  // Normalization and special-case selection, evaluated in NORM.
  always_comb begin
    norm_lo_c = ~q[QBITS-1];
    e_c       = EXP_CALC_W'({2'b00, ea_q}) - EXP_CALC_W'({2'b00, eb_q})
              + EXP_CALC_W'(BIAS) - EXP_CALC_W'(norm_lo_c);
    frac_c    = q[QBITS-1] ? q[QBITS-2 -: MANT_W] : q[QBITS-3 -: MANT_W];
    f_c       = {sign_q, e_c[EXP_W-1:0], frac_c};
    dz_c      = 1'b0;
    if (bz_q) begin
      f_c  = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      dz_c = 1'b1;
    end else if (az_q) begin
      f_c = {sign_q, {(EXP_W + MANT_W){1'b0}}};
    end else if ($signed(e_c) <= $signed(EXP_CALC_W'(0))) begin
      f_c = {sign_q, {(EXP_W + MANT_W){1'b0}}};
    end else if ($signed(e_c) >= $signed(EXP_CALC_W'(255))) begin
      f_c = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      F         <= '0;
      dz        <= 1'b0;
      sign_q    <= 1'b0;
      bz_q      <= 1'b0;
      az_q      <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == ST_IDLE);
      out_valid <= (state_n == ST_DONE);
      // Sign and classification frozen at acceptance.
      if (start_c) begin
        sign_q <= A[31] ^ B[31];
        ea_q   <= A[30:23];
        eb_q   <= B[30:23];
        az_q   <= (A[30:23] == '0);
        bz_q   <= (B[30:23] == '0);
      end
      if (state == ST_NORM) begin
        F  <= f_c;
        dz <= dz_c;
      end
    end
  end

endmodule
